// File: rtl/cmd_pkg.sv
// Shared definitions for the command sequencer: opcodes, enable bit indices,
// FSM state encoding and the opcode-to-enable decode.
package cmd_pkg;

   localparam int unsigned NUM_OPS = 6;

   localparam logic [7:0] OpWrA   = 8'h01;
   localparam logic [7:0] OpWrB   = 8'h02;
   localparam logic [7:0] OpReadA = 8'h03;
   localparam logic [7:0] OpReadB = 8'h04;
   localparam logic [7:0] OpSum   = 8'h05;
   localparam logic [7:0] OpAvg   = 8'h06;
   localparam logic [7:0] OpMan   = 8'h07;
   localparam logic [7:0] OpDot   = 8'h08;

   localparam int unsigned EnAvg   = 0;
   localparam int unsigned EnSum   = 1;
   localparam int unsigned EnReadA = 2;
   localparam int unsigned EnReadB = 3;
   localparam int unsigned EnMan   = 4;
   localparam int unsigned EnDot   = 5;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StStart,
      StWaitOp,
      StWaitTx
   } state_e;

   // Zero result means the opcode is not a compute/read command.
   function automatic logic [NUM_OPS-1:0] op_enables(input logic [7:0] opcode);
      logic [NUM_OPS-1:0] en;
      en = '0;
      case (opcode)
         OpReadA: en[EnReadA] = 1'b1;
         OpReadB: en[EnReadB] = 1'b1;
         OpSum:   en[EnSum]   = 1'b1;
         OpAvg:   en[EnAvg]   = 1'b1;
         OpMan:   en[EnMan]   = 1'b1;
         OpDot:   en[EnDot]   = 1'b1;
         default: en = '0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/payload_loader.sv
// Streams payload bytes into operand memory A or B with registered write strobes.
// Optional inter-byte timeout is compiled in with CMD_TIMEOUT_EN.
module payload_loader
   import cmd_pkg::*;
#(
   parameter int unsigned N_ELEMS    = 1024,
   parameter int unsigned ELEM_W     = 8,
   parameter int unsigned ADDR_W     = $clog2(N_ELEMS),
   parameter int unsigned RX_TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bank_b_sel,
   input  logic              active,
   input  logic              rx_ready,
   input  logic [7:0]        rx_data,
   output logic              wr_en_a,
   output logic              wr_en_b,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ELEM_W-1:0] wr_data,
   output logic              last,
   output logic              timeout
);

   logic [ADDR_W-1:0] cnt_q;
   logic              bank_b_q;
   logic              is_last;

   assign is_last = (cnt_q == ADDR_W'(N_ELEMS - 1));
   assign last    = active && rx_ready && is_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         bank_b_q <= 1'b0;
         wr_en_a  <= 1'b0;
         wr_en_b  <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
      end else begin
         wr_en_a <= 1'b0;
         wr_en_b <= 1'b0;
         if (start) begin
            cnt_q    <= '0;
            bank_b_q <= bank_b_sel;
         end else if (active && rx_ready) begin
            wr_en_a <= !bank_b_q;
            wr_en_b <= bank_b_q;
            wr_addr <= cnt_q;
            wr_data <= rx_data[ELEM_W-1:0];
            // Hold at the final address rather than wrapping.
            if (!is_last) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

`ifdef CMD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(RX_TIMEOUT + 1);

   logic [TW-1:0] idle_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idle_q <= '0;
      end else if (start || rx_ready || !active) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + 1'b1;
      end
   end

   assign timeout = active && !rx_ready && (idle_q == TW'(RX_TIMEOUT - 1));
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^RX_TIMEOUT;
   assign timeout            = 1'b0;
`endif

endmodule

// File: rtl/cmd_sequencer.sv
// Command front end: decodes UART opcodes, loads operand memories, sequences the
// datapath and holds enables until the result is sent. Timeout via CMD_TIMEOUT_EN.
module cmd_sequencer
   import cmd_pkg::*;
#(
   parameter int unsigned N_ELEMS    = 1024,
   parameter int unsigned ELEM_W     = 8,
   parameter int unsigned ADDR_W     = $clog2(N_ELEMS),
   parameter int unsigned RX_TIMEOUT = 1_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         rx_data,
   input  logic               rx_ready,
   output logic               wr_en_a,
   output logic               wr_en_b,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [ELEM_W-1:0]  wr_data,
   output logic [NUM_OPS-1:0] enables,
   output logic               op_start,
   input  logic               op_done,
   input  logic               tx_done,
   output logic               busy,
   output logic               load_done,
   output logic               cmd_error
);

   state_e             state_q, state_d;
   logic [NUM_OPS-1:0] enables_q, enables_d;
   logic               load_done_q, load_done_d;
   logic               cmd_error_q, cmd_error_d;
   logic               load_start;
   logic               ld_last;
   logic               ld_timeout;
   logic [NUM_OPS-1:0] dec_en;

   assign dec_en = op_enables(rx_data);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         enables_q   <= '0;
         load_done_q <= 1'b0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         enables_q   <= enables_d;
         load_done_q <= load_done_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      enables_d   = enables_q;
      load_done_d = 1'b0;
      cmd_error_d = 1'b0;
      load_start  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_ready) begin
               if (rx_data == OpWrA || rx_data == OpWrB) begin
                  load_start = 1'b1;
                  state_d    = StLoad;
               end else if (dec_en != '0) begin
                  enables_d = dec_en;
                  state_d   = StStart;
               end else begin
                  cmd_error_d = 1'b1;
               end
            end
         end
         StLoad: begin
            if (ld_last) begin
               load_done_d = 1'b1;
               state_d     = StIdle;
            end else if (ld_timeout) begin
               cmd_error_d = 1'b1;
               state_d     = StIdle;
            end
         end
         StStart: state_d = StWaitOp;
         // tx_done is deliberately ignored until op_done has been seen.
         StWaitOp: begin
            if (op_done) begin
               state_d = StWaitTx;
            end
         end
         StWaitTx: begin
            if (tx_done) begin
               enables_d = '0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   payload_loader #(
      .N_ELEMS   (N_ELEMS),
      .ELEM_W    (ELEM_W),
      .ADDR_W    (ADDR_W),
      .RX_TIMEOUT(RX_TIMEOUT)
   ) u_loader (
      .clk       (clk),
      .reset     (reset),
      .start     (load_start),
      .bank_b_sel(rx_data == OpWrB),
      .active    (state_q == StLoad),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .wr_en_a   (wr_en_a),
      .wr_en_b   (wr_en_b),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .last      (ld_last),
      .timeout   (ld_timeout)
   );

   assign enables   = enables_q;
   assign load_done = load_done_q;
   assign cmd_error = cmd_error_q;
   assign op_start  = (state_q == StStart);
   assign busy      = (state_q != StIdle);

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command front end of the vector-processing core. Consumes bytes from the UART receiver, decodes one-byte opcodes, streams vector payloads into operand memories A/B, and issues one-hot operation enables plus a start pulse to the datapath. Holds enables stable until the transmit controller reports the result fully sent, so `txCtrl` sees a consistent `enables` from `op_done` through `tx_done`.

## Interface
- `N_ELEMS`, 1024: elements per vector (bytes per write command)
- `ELEM_W`, 8: element width; equals UART byte width
- `ADDR_W`, $clog2(N_ELEMS): memory address width
- `RX_TIMEOUT`, 1_000_000: idle clocks allowed between payload bytes (only with timeout compiled in)

- `clk` in 1: single system clock
- `reset` in 1: asynchronous, active-high
- `rx_data` in 8: received byte, valid when `rx_ready`=1
- `rx_ready` in 1: one-cycle strobe per received byte
- `wr_en_a` / `wr_en_b` out 1: write strobe to memory A / B
- `wr_addr` out ADDR_W: write address
- `wr_data` out ELEM_W: write data
- `enables` out 6: one-hot op select: [0] avg, [1] sum, [2] readA, [3] readB, [4] man, [5] dot
- `op_start` out 1: one-cycle pulse starting the datapath
- `op_done` in 1: datapath finished (pulse or level)
- `tx_done` in 1: `txCtrl` finished sending the result
- `busy` out 1: high in any state except IDLE
- `load_done` out 1: one-cycle pulse after last payload byte written
- `cmd_error` out 1: one-cycle pulse on bad opcode or timeout

## Operation
- Opcodes: 0x01 write A, 0x02 write B, 0x03 readA, 0x04 readB, 0x05 sum, 0x06 avg, 0x07 man, 0x08 dot. Other values: `cmd_error` pulse, stay IDLE.
- States: IDLE, LOAD, START, WAIT_OP, WAIT_TX.
- IDLE + `rx_ready` + write opcode -> LOAD, element counter=0, target bank latched.
- LOAD: each `rx_ready` registers `wr_data`=`rx_data`, `wr_addr`=counter, asserts selected `wr_en_*` for one cycle, counter+1. Write of element N_ELEMS-1 -> `load_done` pulse, IDLE. Counter never wraps.
- IDLE + `rx_ready` + compute/read opcode -> `enables` loaded, START.
- START: `op_start`=1 for one cycle -> WAIT_OP.
- WAIT_OP: `op_done`=1 -> WAIT_TX. `tx_done` ignored here.
- WAIT_TX: `tx_done`=1 -> `enables` cleared, IDLE.
- `rx_ready` in START/WAIT_OP/WAIT_TX: byte dropped, no side effect.
- Reset mid-operation: immediate return to IDLE, all outputs zero, partial load abandoned (memory contents undefined).

## Timing
- Reset values: all outputs 0; state IDLE; counter 0.
- Opcode strobe at cycle T -> `enables` valid and `op_start`=1 at T+1; `enables` held until cycle after `tx_done`.
- Payload byte strobe at T -> `wr_en_*`, `wr_addr`, `wr_data` valid at T+1 for exactly one cycle.
- Last payload strobe at T -> `load_done`=1 at T+1, `busy`=0 at T+1.
- Bad opcode at T -> `cmd_error`=1 at T+1.
- `busy` registered, asserted at T+1 after accepted opcode.
- `op_done` and `tx_done` in same cycle while WAIT_OP: go to WAIT_TX only; next `tx_done` required.

## Configuration
- `CMD_TIMEOUT_EN` defined: LOAD has inter-byte counter reset on each `rx_ready`; reaching RX_TIMEOUT -> `cmd_error` pulse, IDLE, no `load_done`.
- Undefined: no counter logic; LOAD waits indefinitely; `cmd_error` only for bad opcodes.

## Structure
- Shared package `cmd_pkg`: opcode constants, `enables` bit indices, state enum, `NUM_OPS`=6.
- Sub-module `payload_loader`: element counter, bank write strobes, optional timeout counter; FSM instantiates it for LOAD.

## Test plan
- N_ELEMS=4: send 0x01,0x11,0x22,0x33,0x44 -> four `wr_en_a` pulses, addr 0..3 / data 0x11..0x44, `load_done` after last, `wr_en_b` never high.
- Send 0x08 -> next cycle `enables`=6'b100000, `op_start` one cycle; pulse `op_done`, then `tx_done` 50 clocks later -> `enables`=0 cycle after `tx_done`, `busy` low.
- Send 0x05, inject 0x07 during WAIT_OP, `op_done`+`tx_done` same cycle -> `enables` stays 6'b000010 until later `tx_done`; dropped byte causes no op.
- Send 0x3C -> `cmd_error` one cycle, `busy` stays 0, `enables`=0.
- With `CMD_TIMEOUT_EN`, RX_TIMEOUT=20: send 0x02,0xAA then silence -> one `wr_en_b`, `cmd_error` after 20 idle clocks, IDLE; without macro -> stays LOAD.
- Assert `reset` during WAIT_TX -> all outputs 0 asynchronously; next 0x06 runs normally with `enables`=6'b000001.
